// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ifu_pkg;

  localparam int unsigned INST_W = 32;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

  // Canonical RISC-V NOP (addi x0, x0, 0), for stages that need a bubble.
  localparam logic [INST_W-1:0] NOP = 32'h0000_0013;

  // Word presented to decode alongside a fetch fault.
  localparam logic [INST_W-1:0] FAULT_INST = '0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } ifu_state_t;

  // Instruction fetches must be word aligned.
  function automatic logic is_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Counts cycles spent waiting for an instruction-memory response.
// Latency: expired is combinational, asserted in the cycle the count reaches TIMEOUT.
// Backpressure: none; clear wins over enable, count saturates at TIMEOUT.
module fetch_timeout_ctr #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] cnt;

  // Saturating wait counter, restarted whenever a new wait begins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != LIMIT)) begin
      cnt <= cnt + CW'(1);
    end
  end

  // The increment in this cycle brings the count to TIMEOUT, so the
  // TIMEOUT-th enabled cycle is the last one spent waiting.
  assign expired = enable && (cnt >= (LIMIT - CW'(1)));

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: owns the PC, reads imem, hands the word to decode; flags misalignment/error/timeout.
// Latency: aligned fetch with zero-wait memory presents inst 3 cycles after fetch_en; misaligned after 1.
// Backpressure: holds request until imem_req_ready and the instruction until inst_ready; no fetch queueing.
module inst_fetch_unit
  import ifu_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT),
  parameter int unsigned       TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic              pc_we,
  input  logic [ADDR_W-1:0] dnpc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  output logic              imem_rsp_ready,
  input  logic [INST_W-1:0] imem_rsp_data,
  input  logic              imem_rsp_err,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_fault
);

  ifu_state_t        state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] fetch_addr;
  logic              dec_hs;
  logic              launch;
  logic              ctr_expired;

  assign dec_hs = inst_valid & inst_ready;

  // The request address is the PC captured at launch, so it cannot move
  // while the request waits for imem_req_ready.
  assign imem_req_addr = inst_pc;

  // Next PC: a redirect beats the sequential advance on a decode handshake.
  always_comb begin
    pc_next = pc;
    if (pc_we) begin
      pc_next = dnpc;
    end else if (dec_hs) begin
      pc_next = pc + ADDR_W'(4);
    end
  end

  // A back-to-back launch from HOLD must use the PC as updated by the
  // handshake happening in the same cycle; from IDLE the current PC is used.
  always_comb begin
    fetch_addr = pc;
    launch     = 1'b0;
    if (state == S_IDLE) begin
      launch = fetch_en;
    end else if (state == S_HOLD) begin
      fetch_addr = pc_next;
      launch     = fetch_en & inst_ready;
    end
  end

  // PC register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

  fetch_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (imem_req_valid & imem_req_ready),
    .enable  (state == S_WAIT),
    .expired (ctr_expired)
  );

  // Fetch FSM with registered handshake and instruction outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      imem_req_valid <= 1'b0;
      imem_rsp_ready <= 1'b0;
      inst_valid     <= 1'b0;
      inst           <= '0;
      inst_pc        <= '0;
      inst_fault     <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_HOLD: begin
          if (launch) begin
            inst_pc <= fetch_addr;
            if (is_aligned(fetch_addr[1:0])) begin
              state          <= S_REQ;
              imem_req_valid <= 1'b1;
              inst_valid     <= 1'b0;
              inst_fault     <= 1'b0;
            end else begin
              // Misaligned: fault straight to decode, memory never sees it.
              state      <= S_HOLD;
              inst_valid <= 1'b1;
              inst       <= FAULT_INST;
              inst_fault <= 1'b1;
            end
          end else if ((state == S_HOLD) && inst_ready) begin
            state      <= S_IDLE;
            inst_valid <= 1'b0;
          end
        end
        S_REQ: begin
          if (imem_req_ready) begin
            state          <= S_WAIT;
            imem_req_valid <= 1'b0;
            imem_rsp_ready <= 1'b1;
          end
        end
        S_WAIT: begin
          // A response arriving in the timeout cycle still wins.
          if (imem_rsp_valid) begin
            state          <= S_HOLD;
            imem_rsp_ready <= 1'b0;
            inst_valid     <= 1'b1;
            inst           <= imem_rsp_err ? FAULT_INST : imem_rsp_data;
            inst_fault     <= imem_rsp_err;
          end else if (ctr_expired) begin
            state          <= S_HOLD;
            imem_rsp_ready <= 1'b0;
            inst_valid     <= 1'b1;
            inst           <= FAULT_INST;
            inst_fault     <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit with a behavioural instruction memory.
// Latency: n/a.
// Backpressure: memory stalls and silence are driven from per-test knobs.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic        pc_we;
  logic [31:0] dnpc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic        imem_rsp_ready;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;

  always #5 clk = ~clk;

  inst_fetch_unit #(
    .ADDR_W   (32),
    .RESET_PC (32'h8000_0000),
    .TIMEOUT  (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .pc_we          (pc_we),
    .dnpc           (dnpc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_ready (imem_rsp_ready),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_fault     (inst_fault)
  );

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fault;
  } exp_t;

  typedef struct {
    string       name;
    bit          redirect;
    logic [31:0] target;
    logic [31:0] data;
    bit          err;
    bit          silent;
    int          stall;
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
    bit          exp_fault;
    int          exp_lat;
    int          exp_reqs;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[8];

  int n_checks = 0;
  int n_pass   = 0;

  // Memory model knobs and state.
  logic [31:0] mem_data;
  bit          mem_err;
  bit          mem_silent;
  int          stall_left;
  int          req_count;
  int          reqs0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // One clock: sample handshakes before the edge, then update the memory model.
  task automatic step();
    bit req_hs;
    bit rsp_hs;
    req_hs = imem_req_valid && imem_req_ready;
    rsp_hs = imem_rsp_valid && imem_rsp_ready;
    @(posedge clk);
    #1;
    if (rsp_hs) begin
      imem_rsp_valid = 1'b0;
      imem_rsp_err   = 1'b0;
      imem_rsp_data  = '0;
    end
    if (req_hs) begin
      req_count++;
      if (!mem_silent) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_data;
        imem_rsp_err   = mem_err;
      end
    end
    if (imem_req_valid && stall_left > 0) begin
      imem_req_ready = 1'b0;
      stall_left--;
    end else begin
      imem_req_ready = 1'b1;
    end
  endtask

  task automatic redirect(input logic [31:0] target);
    pc_we = 1'b1;
    dnpc  = target;
    step();
    pc_we = 1'b0;
  endtask

  task automatic accept();
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
  endtask

  task automatic check_output(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      $display("FAIL %s scoreboard: got empty queue expected an entry", tag);
      return;
    end
    e = sb.pop_front();
    check({tag, " inst"}, inst, e.inst);
    check({tag, " inst_pc"}, inst_pc, e.pc);
    check({tag, " fault"}, inst_fault, e.fault);
  endtask

  task automatic await_inst(input string tag, input int start_lat, input int elat);
    int lat = start_lat;
    while (!inst_valid && lat < 60) begin
      step();
      lat++;
    end
    check({tag, " latency"}, lat, elat);
    if (inst_valid) begin
      check_output(tag);
    end else begin
      n_checks++;
      $display("FAIL %s inst_valid: got 0 expected 1 within budget", tag);
      if (sb.size() > 0) void'(sb.pop_front());
    end
  endtask

  task automatic do_fetch(input string tag, input logic [31:0] epc, input logic [31:0] einst,
                          input bit efault, input int elat, input int ereqs, input bit acc);
    int r0;
    r0 = req_count;
    sb.push_back('{einst, epc, efault});
    fetch_en = 1'b1;
    step();
    fetch_en = 1'b0;
    await_inst(tag, 1, elat);
    check({tag, " requests"}, req_count - r0, ereqs);
    if (acc) accept();
  endtask

  initial begin
    //         name        redir target         data           err sil stall exp_pc         exp_inst       flt lat reqs
    vecs[0] = '{"first",    0, 32'h0,          32'h0000_0413, 0,  0,  0,  32'h8000_0000, 32'h0000_0413, 0,  3,  1};
    vecs[1] = '{"seq+4",    0, 32'h0,          32'h0010_0093, 0,  0,  0,  32'h8000_0004, 32'h0010_0093, 0,  3,  1};
    vecs[2] = '{"misalign", 1, 32'h8000_0102,  32'h1111_1111, 0,  0,  0,  32'h8000_0102, 32'h0,         1,  1,  0};
    vecs[3] = '{"rsp_err",  1, 32'h8000_0200,  32'hDEAD_BEEF, 1,  0,  0,  32'h8000_0200, 32'h0,         1,  3,  1};
    vecs[4] = '{"timeout",  0, 32'h0,          32'h2222_2222, 0,  1,  0,  32'h8000_0204, 32'h0,         1,  6,  1};
    vecs[5] = '{"stall2",   1, 32'h8000_0300,  32'h1234_5678, 0,  0,  2,  32'h8000_0300, 32'h1234_5678, 0,  5,  1};
    vecs[6] = '{"top_pc",   1, 32'hFFFF_FFFC,  32'hCAFE_F00D, 0,  0,  0,  32'hFFFF_FFFC, 32'hCAFE_F00D, 0,  3,  1};
    vecs[7] = '{"wrap",     0, 32'h0,          32'h0BAD_C0DE, 0,  0,  0,  32'h0000_0000, 32'h0BAD_C0DE, 0,  3,  1};

    rst            = 1'b1;
    fetch_en       = 1'b0;
    pc_we          = 1'b0;
    dnpc           = '0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    imem_rsp_err   = 1'b0;
    inst_ready     = 1'b0;
    mem_data       = '0;
    mem_err        = 1'b0;
    mem_silent     = 1'b0;
    stall_left     = 0;
    req_count      = 0;

    repeat (2) @(posedge clk);
    #1;
    check("reset req_valid", imem_req_valid, 0);
    check("reset rsp_ready", imem_rsp_ready, 0);
    check("reset inst_valid", inst_valid, 0);
    check("reset inst", inst, 0);
    check("reset inst_pc", inst_pc, 0);
    check("reset inst_fault", inst_fault, 0);
    rst = 1'b0;

    // Table-driven fetches.
    for (int i = 0; i < 8; i++) begin
      mem_data   = vecs[i].data;
      mem_err    = vecs[i].err;
      mem_silent = vecs[i].silent;
      stall_left = vecs[i].stall;
      if (vecs[i].redirect) redirect(vecs[i].target);
      do_fetch(vecs[i].name, vecs[i].exp_pc, vecs[i].exp_inst, vecs[i].exp_fault,
               vecs[i].exp_lat, vecs[i].exp_reqs, 1'b1);
    end
    mem_err    = 1'b0;
    mem_silent = 1'b0;

    // Request held stable across a 5-cycle memory stall.
    mem_data = 32'h0000_0513;
    redirect(32'h8000_0000);
    reqs0 = req_count;
    sb.push_back('{32'h0000_0513, 32'h8000_0000, 1'b0});
    stall_left = 5;
    fetch_en   = 1'b1;
    step();
    fetch_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall c%0d req_valid", i), imem_req_valid, 1);
      check($sformatf("stall c%0d req_addr", i), imem_req_addr, 32'h8000_0000);
      check($sformatf("stall c%0d req_ready low", i), imem_req_ready, 0);
      step();
    end
    await_inst("stall5", 6, 8);
    check("stall5 single handshake", req_count - reqs0, 1);
    accept();

    // Redirect coinciding with decode handshake and a back-to-back fetch.
    mem_data = 32'h0050_0113;
    redirect(32'h8000_0400);
    do_fetch("pre_b2b", 32'h8000_0400, 32'h0050_0113, 1'b0, 3, 1, 1'b0);
    mem_data = 32'h00A0_0193;
    sb.push_back('{32'h00A0_0193, 32'h8000_1000, 1'b0});
    inst_ready = 1'b1;
    pc_we      = 1'b1;
    dnpc       = 32'h8000_1000;
    fetch_en   = 1'b1;
    step();
    inst_ready = 1'b0;
    pc_we      = 1'b0;
    fetch_en   = 1'b0;
    check("b2b redirect req_valid", imem_req_valid, 1);
    check("b2b redirect req_addr", imem_req_addr, 32'h8000_1000);
    check("b2b redirect inst_valid low", inst_valid, 0);
    await_inst("b2b_redirect", 1, 3);
    mem_data = 32'h00F0_0213;
    sb.push_back('{32'h00F0_0213, 32'h8000_1004, 1'b0});
    inst_ready = 1'b1;
    fetch_en   = 1'b1;
    step();
    inst_ready = 1'b0;
    fetch_en   = 1'b0;
    check("b2b seq req_valid", imem_req_valid, 1);
    check("b2b seq req_addr", imem_req_addr, 32'h8000_1004);
    await_inst("b2b_seq", 1, 3);
    accept();

    // Asynchronous reset while waiting on memory.
    mem_silent = 1'b1;
    fetch_en   = 1'b1;
    step();
    fetch_en = 1'b0;
    step();
    check("pre-reset in WAIT rsp_ready", imem_rsp_ready, 1);
    rst = 1'b1;
    #1;
    check("async rst req_valid", imem_req_valid, 0);
    check("async rst rsp_ready", imem_rsp_ready, 0);
    check("async rst inst_valid", inst_valid, 0);
    check("async rst inst", inst, 0);
    check("async rst inst_pc", inst_pc, 0);
    check("async rst inst_fault", inst_fault, 0);
    imem_rsp_valid = 1'b0;
    imem_rsp_err   = 1'b0;
    imem_req_ready = 1'b1;
    stall_left     = 0;
    sb.delete();
    #1;
    rst        = 1'b0;
    mem_silent = 1'b0;
    mem_data   = 32'h0000_0793;
    do_fetch("after_rst", 32'h8000_0000, 32'h0000_0793, 1'b0, 3, 1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
